vx_mem_tag_bridge: RTL and testbench



---
 rtl/vx_mem_tag_bridge.sv | 105 ++++++++++
 tb/tb_vx_mem_tag_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_tag_bridge.sv
// vx_mem_tag_bridge: compresses wide GPU memory tags into slot indices for the memory controller and restores them on read responses.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   in_req_*                      GPU-side request (valid/ready, rw, byteen, addr, data, tag)
//   in_rsp_*                      GPU-side response (valid/ready, data, restored tag)
//   out_req_*                     memory-side request; tag is the slot index for reads, 0 for writes
//   out_rsp_*                     memory-side read response carrying a slot index
//   pending                       number of allocated slots
//   busy                          slots allocated or either output register holding data
module vx_mem_tag_bridge #(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 56,
  parameter int NUM_SLOTS    = 16,
  parameter int SLOT_BITS    = $clog2(NUM_SLOTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_req_valid,
  output logic                    in_req_ready,
  input  logic                    in_req_rw,
  input  logic [DATA_WIDTH/8-1:0] in_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [DATA_WIDTH-1:0]   in_req_data,
  input  logic [TAG_IN_WIDTH-1:0] in_req_tag,
  output logic                    in_rsp_valid,
  input  logic                    in_rsp_ready,
  output logic [DATA_WIDTH-1:0]   in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0] in_rsp_tag,
  output logic                    out_req_valid,
  input  logic                    out_req_ready,
  output logic                    out_req_rw,
  output logic [DATA_WIDTH/8-1:0] out_req_byteen,
  output logic [ADDR_WIDTH-1:0]   out_req_addr,
  output logic [DATA_WIDTH-1:0]   out_req_data,
  output logic [SLOT_BITS-1:0]    out_req_tag,
  input  logic                    out_rsp_valid,
  output logic                    out_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   out_rsp_data,
  input  logic [SLOT_BITS-1:0]    out_rsp_tag,
  output logic [SLOT_BITS:0]      pending,
  output logic                    busy
);
  logic [NUM_SLOTS-1:0]    slot_valid;
  logic [TAG_IN_WIDTH-1:0] slot_tag [NUM_SLOTS];
  logic [SLOT_BITS-1:0]    free_idx;
  logic [SLOT_BITS-1:0]    rsp_slot;
  logic any_free, req_stage_ready, req_fire, alloc, rsp_fire, free_fire, dec;
  // Lowest free slot, from the registered valid bits only: a slot freed this
  // cycle becomes allocatable next cycle.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_idx = SLOT_BITS'(i);
        any_free = 1'b1;
      end
    end
  end
  assign req_stage_ready = !out_req_valid || out_req_ready;
  assign in_req_ready    = req_stage_ready && (in_req_rw || any_free);
  assign req_fire        = in_req_valid && in_req_ready;
  assign alloc           = req_fire && !in_req_rw;
  assign out_rsp_ready   = !in_rsp_valid || in_rsp_ready;
  assign rsp_fire        = out_rsp_valid && out_rsp_ready;
  assign free_fire       = in_rsp_valid && in_rsp_ready;
  // A stray response to an unallocated slot must not underflow the count.
  assign dec             = free_fire && slot_valid[rsp_slot];
  assign busy            = (pending != '0) || out_req_valid || in_rsp_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_req_valid <= 1'b0;
      in_rsp_valid  <= 1'b0;
      slot_valid    <= '0;
      pending       <= '0;
    end else begin
      if (req_stage_ready) out_req_valid <= req_fire;
      if (out_rsp_ready) in_rsp_valid <= out_rsp_valid;
      slot_valid <= (slot_valid & ~(NUM_SLOTS'(free_fire) << rsp_slot)) | (NUM_SLOTS'(alloc) << free_idx);
      pending    <= pending + (SLOT_BITS+1)'(alloc) - (SLOT_BITS+1)'(dec);
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) begin
      out_req_rw     <= in_req_rw;
      out_req_byteen <= in_req_byteen;
      out_req_addr   <= in_req_addr;
      out_req_data   <= in_req_data;
      out_req_tag    <= in_req_rw ? '0 : free_idx;
    end
    if (alloc) slot_tag[free_idx] <= in_req_tag;
    if (rsp_fire) begin
      in_rsp_data <= out_rsp_data;
      in_rsp_tag  <= slot_tag[out_rsp_tag];
      rsp_slot    <= out_rsp_tag;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && rsp_fire && !slot_valid[out_rsp_tag])
      $error("vx_mem_tag_bridge: response to unallocated slot %0d", out_rsp_tag);
  end
`endif
endmodule

// File: tb/tb_vx_mem_tag_bridge.sv
// tb_vx_mem_tag_bridge: table-driven, directed and randomized checks of vx_mem_tag_bridge.
module tb_vx_mem_tag_bridge;
  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 56;
  localparam int NS = 16;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_req_valid, in_req_ready, in_req_rw;
  logic [DW/8-1:0] in_req_byteen;
  logic [AW-1:0] in_req_addr;
  logic [DW-1:0] in_req_data;
  logic [TW-1:0] in_req_tag;
  logic          in_rsp_valid, in_rsp_ready;
  logic [DW-1:0] in_rsp_data;
  logic [TW-1:0] in_rsp_tag;
  logic          out_req_valid, out_req_ready, out_req_rw;
  logic [DW/8-1:0] out_req_byteen;
  logic [AW-1:0] out_req_addr;
  logic [DW-1:0] out_req_data;
  logic [SB-1:0] out_req_tag;
  logic          out_rsp_valid, out_rsp_ready;
  logic [DW-1:0] out_rsp_data;
  logic [SB-1:0] out_rsp_tag;
  logic [SB:0]   pending;
  logic          busy;

  always #5 clk = ~clk;

  vx_mem_tag_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .NUM_SLOTS(NS)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_byteen(in_req_byteen), .in_req_addr(in_req_addr), .in_req_data(in_req_data),
    .in_req_tag(in_req_tag),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
    .out_req_byteen(out_req_byteen), .out_req_addr(out_req_addr), .out_req_data(out_req_data),
    .out_req_tag(out_req_tag),
    .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag),
    .pending(pending), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E3779B1 + 32'h00005a5a;
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    in_req_valid  = 1'b0;
    in_req_rw     = 1'b0;
    in_req_byteen = '1;
    in_req_addr   = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    out_req_ready = 1'b1;
    in_rsp_ready  = 1'b1;
    out_rsp_valid = 1'b0;
    out_rsp_tag   = '0;
    out_rsp_data  = '0;
  endtask

  task automatic rd(input logic [TW-1:0] tag, input logic [AW-1:0] addr);
    in_req_valid = 1'b1;
    in_req_rw    = 1'b0;
    in_req_tag   = tag;
    in_req_addr  = addr;
  endtask

  task automatic chk_idle_state(input string name);
    chk({name, "_pending"}, pending, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_out_req_valid"}, out_req_valid, 0);
    chk({name, "_in_rsp_valid"}, in_rsp_valid, 0);
  endtask

  typedef struct {
    logic rv; logic rw; logic [TW-1:0] tag; logic mv; logic [SB-1:0] mtag; logic gr;
    logic e_rdy; logic e_oqv; logic [SB-1:0] e_oqt; logic e_irv; logic [TW-1:0] e_irt;
    logic [SB:0] e_pend; logic e_busy;
  } vec_t;

  function automatic vec_t mk(input int rv, input int rw, input logic [TW-1:0] tag, input int mv,
                              input int mtag, input int gr, input int e_rdy, input int e_oqv,
                              input int e_oqt, input int e_irv, input logic [TW-1:0] e_irt,
                              input int e_pend, input int e_busy);
    vec_t v;
    v.rv = rv[0]; v.rw = rw[0]; v.tag = tag; v.mv = mv[0]; v.mtag = mtag[SB-1:0]; v.gr = gr[0];
    v.e_rdy = e_rdy[0]; v.e_oqv = e_oqv[0]; v.e_oqt = e_oqt[SB-1:0]; v.e_irv = e_irv[0];
    v.e_irt = e_irt; v.e_pend = e_pend[SB:0]; v.e_busy = e_busy[0];
    return v;
  endfunction

  localparam logic [TW-1:0] Z  = 56'h0;
  localparam logic [TW-1:0] T0 = 56'h123456;
  localparam logic [TW-1:0] TA = 56'hAA_0000_A0A0;
  localparam logic [TW-1:0] TB = 56'hBB_0000_B0B0;
  localparam logic [TW-1:0] TC = 56'hCC_0000_C0C0;
  localparam logic [TW-1:0] TD = 56'hDD_0000_D0D0;

  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW/8-1:0] be; } req_t;
  typedef struct { logic [TW-1:0] tag; logic [AW-1:0] addr; } exp_t;
  typedef struct { logic [SB-1:0] slot; logic [AW-1:0] addr; } mem_t;
  req_t req_q[$];
  exp_t exp_q[$];
  mem_t mem_q[$];
  int model_count = 0;
  int rsp_inflight = 0;
  int mem_sel = 0;
  int tag_ctr = 0;
  bit req_hold = 1'b0;
  bit mem_hold = 1'b0;

  task automatic step(input bit drain);
    req_t r;
    int idx;
    chk("rnd_pending", pending, model_count);
    chk("rnd_busy", busy, (model_count != 0 || req_q.size() != 0 || rsp_inflight != 0));
    if (drain) begin
      in_req_valid = 1'b0;
    end else if (!req_hold) begin
      tag_ctr++;
      in_req_valid  = $urandom_range(0, 99) < 60;
      in_req_rw     = $urandom_range(0, 99) < 30;
      in_req_tag    = {24'($urandom), 32'(tag_ctr)};
      in_req_addr   = AW'($urandom);
      in_req_data   = rnd_wide();
      in_req_byteen = {$urandom, $urandom};
    end
    out_req_ready = drain ? 1'b1 : ($urandom_range(0, 99) < 75);
    in_rsp_ready  = drain ? 1'b1 : ($urandom_range(0, 99) < 70);
    if (!mem_hold) begin
      if (mem_q.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        mem_sel       = $urandom_range(0, mem_q.size() - 1);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = mem_q[mem_sel].slot;
        out_rsp_data  = mdata(mem_q[mem_sel].addr);
      end else begin
        out_rsp_valid = 1'b0;
      end
    end
    #1;
    chk("rnd_in_req_ready", in_req_ready,
        (req_q.size() == 0 || out_req_ready) && (in_req_rw || model_count < NS));
    chk("rnd_out_rsp_ready", out_rsp_ready, rsp_inflight == 0 || in_rsp_ready);
    if (out_req_valid && out_req_ready) begin
      if (req_q.size() == 0) begin
        chk("rnd_spurious_out_req", 1, 0);
      end else begin
        r = req_q.pop_front();
        chk("rnd_out_rw", out_req_rw, r.rw);
        chk("rnd_out_addr", out_req_addr, r.addr);
        chk("rnd_out_data", out_req_data, r.data);
        chk("rnd_out_byteen", out_req_byteen, r.be);
        if (r.rw) chk("rnd_write_tag", out_req_tag, 0);
        else mem_q.push_back('{out_req_tag, r.addr});
      end
    end
    if (in_req_valid && in_req_ready) begin
      req_q.push_back('{in_req_rw, in_req_addr, in_req_data, in_req_byteen});
      if (!in_req_rw) begin
        exp_q.push_back('{in_req_tag, in_req_addr});
        model_count++;
      end
    end
    req_hold = in_req_valid && !in_req_ready;
    mem_hold = out_rsp_valid && !out_rsp_ready;
    if (out_rsp_valid && out_rsp_ready) begin
      mem_q.delete(mem_sel);
      rsp_inflight++;
    end
    if (in_rsp_valid && in_rsp_ready) begin
      idx = -1;
      foreach (exp_q[k]) if (exp_q[k].tag == in_rsp_tag && idx < 0) idx = k;
      if (idx < 0) begin
        chk("rnd_rsp_tag_known", in_rsp_tag, 0);
      end else begin
        chk("rnd_rsp_data", in_rsp_data, mdata(exp_q[idx].addr));
        exp_q.delete(idx);
      end
      model_count--;
      rsp_inflight--;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[13];
    int n;
    vt[0]  = mk(1, 0, T0, 0, 0, 1, 1, 1, 0, 0, Z,  1, 1);
    vt[1]  = mk(0, 0, Z,  1, 0, 1, 1, 0, 0, 1, T0, 1, 1);
    vt[2]  = mk(0, 0, Z,  0, 0, 1, 1, 0, 0, 0, Z,  0, 0);
    vt[3]  = mk(1, 0, TA, 0, 0, 1, 1, 1, 0, 0, Z,  1, 1);
    vt[4]  = mk(1, 0, TB, 0, 0, 1, 1, 1, 1, 0, Z,  2, 1);
    vt[5]  = mk(1, 0, TC, 0, 0, 1, 1, 1, 2, 0, Z,  3, 1);
    vt[6]  = mk(0, 0, Z,  1, 2, 1, 1, 0, 0, 1, TC, 3, 1);
    vt[7]  = mk(0, 0, Z,  0, 0, 1, 1, 0, 0, 0, Z,  2, 1);
    vt[8]  = mk(1, 0, TD, 0, 0, 1, 1, 1, 2, 0, Z,  3, 1);
    vt[9]  = mk(0, 0, Z,  1, 0, 1, 1, 0, 0, 1, TA, 3, 1);
    vt[10] = mk(0, 0, Z,  1, 1, 1, 1, 0, 0, 1, TB, 2, 1);
    vt[11] = mk(0, 0, Z,  1, 2, 1, 1, 0, 0, 1, TD, 1, 1);
    vt[12] = mk(0, 0, Z,  0, 0, 1, 1, 0, 0, 0, Z,  0, 0);

    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_state("reset");
    chk("reset_in_req_ready", in_req_ready, 1);
    chk("reset_out_rsp_ready", out_rsp_ready, 1);

    for (int i = 0; i < 13; i++) begin
      in_req_valid = vt[i].rv;
      in_req_rw    = vt[i].rw;
      in_req_tag   = vt[i].tag;
      in_req_addr  = AW'(26'h40);
      out_rsp_valid = vt[i].mv;
      out_rsp_tag  = vt[i].mtag;
      out_rsp_data = mdata(AW'(i));
      in_rsp_ready = vt[i].gr;
      #1;
      chk($sformatf("vec%0d_in_req_ready", i), in_req_ready, vt[i].e_rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_out_req_valid", i), out_req_valid, vt[i].e_oqv);
      if (vt[i].e_oqv) chk($sformatf("vec%0d_out_req_tag", i), out_req_tag, vt[i].e_oqt);
      chk($sformatf("vec%0d_in_rsp_valid", i), in_rsp_valid, vt[i].e_irv);
      if (vt[i].e_irv) chk($sformatf("vec%0d_in_rsp_tag", i), in_rsp_tag, vt[i].e_irt);
      chk($sformatf("vec%0d_pending", i), pending, vt[i].e_pend);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
    end
    idle();

    for (int i = 0; i < NS; i++) begin
      rd(TW'(32'h1000 + i), AW'(i));
      #1 chk($sformatf("fill%0d_ready", i), in_req_ready, 1);
      @(negedge clk);
      chk($sformatf("fill%0d_valid", i), out_req_valid, 1);
      chk($sformatf("fill%0d_slot", i), out_req_tag, i);
    end
    rd(TW'(32'h2000), AW'(0));
    #1 chk("full_read_stalled", in_req_ready, 0);
    in_req_rw = 1'b1;
    #1 chk("full_write_ready", in_req_ready, 1);
    @(negedge clk);
    chk("full_write_valid", out_req_valid, 1);
    chk("full_write_rw", out_req_rw, 1);
    chk("full_write_tag", out_req_tag, 0);
    chk("full_pending", pending, 16);
    in_req_valid = 1'b0;
    in_req_rw    = 1'b0;

    in_rsp_ready  = 1'b0;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = 4'd3;
    @(negedge clk);
    chk("sim_rsp_valid", in_rsp_valid, 1);
    chk("sim_rsp_tag", in_rsp_tag, TW'(32'h1003));
    out_rsp_valid = 1'b0;
    in_rsp_ready  = 1'b1;
    rd(TW'(32'h3000), AW'(3));
    #1 chk("sim_read_stalled", in_req_ready, 0);
    @(negedge clk);
    chk("sim_rsp_delivered", in_rsp_valid, 0);
    #1 chk("sim_read_ready_next", in_req_ready, 1);
    @(negedge clk);
    chk("sim_realloc_slot", out_req_tag, 3);
    chk("sim_pending", pending, 16);
    in_req_valid = 1'b0;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_state("reset_full");

    rd(TW'(56'hE0), AW'(1));
    @(negedge clk);
    rd(TW'(56'hE1), AW'(2));
    @(negedge clk);
    in_req_valid  = 1'b0;
    in_rsp_ready  = 1'b0;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = 4'd0;
    out_rsp_data  = mdata(AW'(1));
    @(negedge clk);
    chk("bp_first_valid", in_rsp_valid, 1);
    chk("bp_first_tag", in_rsp_tag, TW'(56'hE0));
    out_rsp_tag  = 4'd1;
    out_rsp_data = mdata(AW'(2));
    #1 chk("bp_out_rsp_ready_low", out_rsp_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_tag", i), in_rsp_tag, TW'(56'hE0));
      chk($sformatf("bp_hold%0d_data", i), in_rsp_data, mdata(AW'(1)));
      chk($sformatf("bp_hold%0d_ready", i), out_rsp_ready, 0);
      chk($sformatf("bp_hold%0d_pending", i), pending, 2);
    end
    in_rsp_ready = 1'b1;
    #1 chk("bp_out_rsp_ready_high", out_rsp_ready, 1);
    @(negedge clk);
    out_rsp_valid = 1'b0;
    chk("bp_second_valid", in_rsp_valid, 1);
    chk("bp_second_tag", in_rsp_tag, TW'(56'hE1));
    chk("bp_second_data", in_rsp_data, mdata(AW'(2)));
    chk("bp_pending1", pending, 1);
    @(negedge clk);
    chk_idle_state("bp_done");

    for (int i = 0; i < 4; i++) begin
      rd(TW'(32'h5000 + i), AW'(i));
      @(negedge clk);
    end
    chk("mid_pending4", pending, 4);
    in_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_state("mid_reset");
    rd(TW'(32'h6000), AW'(7));
    @(negedge clk);
    chk("mid_new_slot", out_req_tag, 0);
    in_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle();

    for (int c = 0; c < 3000; c++) step(1'b0);
    n = 0;
    while ((model_count != 0 || req_q.size() != 0 || rsp_inflight != 0) && n < 1000) begin
      step(1'b1);
      n++;
    end
    chk("drain_completed", n < 1000, 1);
    idle();
    @(negedge clk);
    chk_idle_state("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
